// File: rtl/stack_unwind_unit.sv
// rtl/stack_unwind_unit.sv - RET/RTI stack pop sequencer
//
// Pops the return PC (low word, then high word) and, for RTI, the saved
// flags word from consecutive ascending stack addresses, one read per
// cycle. It then hands the reassembled PC, restored flags and new SP to
// fetch / flag register / SP register as single-cycle pulses.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request from memory stage, sampled only in IDLE
//   restore_flags       1 = RTI (also pop flags), 0 = RET; sampled with start
//   sp_in               current SP, sampled with start
//   mem_rdata           synchronous memory data, valid the cycle after mem_rd
//   mem_rd, mem_addr    data memory read request
//   stall               pipeline freeze (start cycle plus every busy cycle)
//   busy                high in every non-IDLE state
//   pc_out, pc_valid    return PC {hi, lo} and its redirect pulse
//   flags_out, flags_valid  restored flags and their pulse (RTI only)
//   sp_out, sp_we       new SP value and its write pulse
module stack_unwind_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 32,
  parameter int FLAGS_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                restore_flags,
  input  logic [ADDR_W-1:0]   sp_in,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                stall,
  output logic                busy,
  output logic [2*DATA_W-1:0] pc_out,
  output logic                pc_valid,
  output logic [FLAGS_W-1:0]  flags_out,
  output logic                flags_valid,
  output logic [ADDR_W-1:0]   sp_out,
  output logic                sp_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_RD_FL,
    S_FIN
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   sp_base;
  logic                rti;
  logic [DATA_W-1:0]   lo_reg;
  logic [DATA_W-1:0]   hi_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and memory request. Address sums wrap modulo 2^ADDR_W.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RD_LO;
      end
      S_RD_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = sp_base + ADDR_W'(1);
        state_nxt = S_RD_HI;
      end
      S_RD_HI: begin
        mem_rd    = 1'b1;
        mem_addr  = sp_base + ADDR_W'(2);
        state_nxt = rti ? S_RD_FL : S_FIN;
      end
      S_RD_FL: begin
        mem_rd    = 1'b1;
        mem_addr  = sp_base + ADDR_W'(3);
        state_nxt = S_FIN;
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // The start cycle itself must also freeze the pipeline.
    stall = ((state == S_IDLE) && start) || busy;
  end

  // Datapath. Each state captures the word requested in the previous state,
  // so the FIN edge sees the last word: high PC for RET, flags for RTI.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_base     <= '0;
      rti         <= 1'b0;
      lo_reg      <= '0;
      hi_reg      <= '0;
      pc_out      <= '0;
      flags_out   <= '0;
      sp_out      <= '0;
      pc_valid    <= 1'b0;
      flags_valid <= 1'b0;
      sp_we       <= 1'b0;
    end else begin
      pc_valid    <= 1'b0;
      flags_valid <= 1'b0;
      sp_we       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sp_base <= sp_in;
            rti     <= restore_flags;
          end
        end
        S_RD_HI: lo_reg <= mem_rdata;
        S_RD_FL: hi_reg <= mem_rdata;
        S_FIN: begin
          pc_valid    <= 1'b1;
          sp_we       <= 1'b1;
          flags_valid <= rti;
          if (rti) begin
            pc_out    <= {hi_reg, lo_reg};
            flags_out <= mem_rdata[FLAGS_W-1:0];
            sp_out    <= sp_base + ADDR_W'(3);
          end else begin
            hi_reg    <= mem_rdata;
            pc_out    <= {mem_rdata, lo_reg};
            sp_out    <= sp_base + ADDR_W'(2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_unwind_unit.sv
// tb/tb_stack_unwind_unit.sv - self-checking bench for stack_unwind_unit
module tb_stack_unwind_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        restore_flags;
  logic [31:0] sp_in;
  logic [15:0] mem_rdata;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        stall;
  logic        busy;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [3:0]  flags_out;
  logic        flags_valid;
  logic [31:0] sp_out;
  logic        sp_we;

  stack_unwind_unit dut (
    .clk(clk), .rst(rst), .start(start), .restore_flags(restore_flags),
    .sp_in(sp_in), .mem_rdata(mem_rdata), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .stall(stall), .busy(busy), .pc_out(pc_out),
    .pc_valid(pc_valid), .flags_out(flags_out), .flags_valid(flags_valid),
    .sp_out(sp_out), .sp_we(sp_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sp;
    logic        rti;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] fl;
    logic [31:0] exp_pc;
    logic [31:0] exp_sp;
    logic [3:0]  exp_fl;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] sp;
    logic        fv;
    logic [3:0]  fl;
  } exp_t;

  logic [15:0] mem [logic [31:0]];
  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;

  // Synchronous memory model: data the cycle after the read request.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Scoreboard: every pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (pc_valid || sp_we || flags_valid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {pc_valid, sp_we, flags_valid}, 3'b000);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_sp", sp_out, e.sp);
        chk("sb_pulses", {pc_valid, sp_we, flags_valid}, {2'b11, e.fv});
        if (e.fv) chk("sb_flags", flags_out, e.fl);
      end
    end
  end

  task automatic step_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input vec_t v);
    int          n;
    int          rd_cnt;
    int          addr_errs;
    int          early;
    logic [7:0]  stall_seen;
    logic [7:0]  stall_exp;
    n = v.rti ? 4 : 3;
    rd_cnt = 0; addr_errs = 0; early = 0;
    stall_seen = '0; stall_exp = '0;
    for (int c = 0; c <= n; c++) stall_exp[c] = 1'b1;
    mem[v.sp + 32'd1] = v.lo;
    mem[v.sp + 32'd2] = v.hi;
    mem[v.sp + 32'd3] = v.fl;
    step_drive();
    start = 1'b1; restore_flags = v.rti; sp_in = v.sp;
    sb.push_back('{v.exp_pc, v.exp_sp, v.rti, v.exp_fl});
    #1;
    stall_seen[0] = stall;
    for (int c = 1; c <= n + 1; c++) begin
      step_drive();
      start = 1'b0; restore_flags = 1'($urandom); sp_in = $urandom;
      #1;
      stall_seen[c] = stall;
      if (mem_rd) begin
        if (mem_addr !== v.sp + 32'(rd_cnt + 1)) addr_errs++;
        rd_cnt++;
      end
      if (c <= n && (pc_valid || sp_we || flags_valid)) early++;
      if (c == n + 1) chk("pulse_cycle", {pc_valid, sp_we, flags_valid}, {2'b11, v.rti});
    end
    chk("stall_pattern", stall_seen, stall_exp);
    chk("rd_count", rd_cnt, n - 1);
    chk("rd_addrs", addr_errs, 0);
    chk("no_early_pulse", early, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int pulses;
    int rds;
    vecs[0] = '{32'h0000_0100, 1'b0, 16'h5678, 16'h1234, 16'h0000, 32'h1234_5678, 32'h0000_0102, 4'h0};
    vecs[1] = '{32'h0000_0200, 1'b1, 16'hBEEF, 16'hDEAD, 16'h000A, 32'hDEAD_BEEF, 32'h0000_0203, 4'hA};
    vecs[2] = '{32'hFFFF_FFFF, 1'b0, 16'h1111, 16'h2222, 16'h0000, 32'h2222_1111, 32'h0000_0001, 4'h0};
    vecs[3] = '{32'hFFFF_FFFE, 1'b1, 16'hAAAA, 16'h5555, 16'hFFF3, 32'h5555_AAAA, 32'h0000_0001, 4'h3};
    vecs[4] = '{32'h0000_1000, 1'b1, 16'h0001, 16'h8000, 16'h0005, 32'h8000_0001, 32'h0000_1003, 4'h5};

    rst = 1'b1; start = 1'b0; restore_flags = 1'b0; sp_in = '0; mem_rdata = '0;
    repeat (2) step_drive();
    rst = 1'b0;
    #1;
    chk("reset_state",
        {busy, stall, mem_rd, mem_addr, pc_out, sp_out, flags_out, pc_valid, flags_valid, sp_we},
        '0);

    // Table vectors run back to back (each starts the cycle after the previous pulse).
    foreach (vecs[i]) run_seq(vecs[i]);

    // Start held through an RET, then a new RET launched in the pulse cycle.
    mem[32'h301] = 16'h4321; mem[32'h302] = 16'h8765;
    mem[32'h401] = 16'h0F0F; mem[32'h402] = 16'hF0F0;
    step_drive();
    start = 1'b1; restore_flags = 1'b0; sp_in = 32'h300;
    sb.push_back('{32'h8765_4321, 32'h302, 1'b0, 4'h0});
    for (int c = 1; c <= 3; c++) begin
      step_drive();
      restore_flags = 1'b1; sp_in = 32'h999;
      #1;
      if (c == 1) chk("held_addr1", {mem_rd, mem_addr}, {1'b1, 32'h301});
      if (c == 2) chk("held_addr2", {mem_rd, mem_addr}, {1'b1, 32'h302});
      if (c == 3) chk("held_fin", {mem_rd, busy, stall}, 3'b011);
    end
    step_drive();
    restore_flags = 1'b0; sp_in = 32'h400;
    sb.push_back('{32'hF0F0_0F0F, 32'h402, 1'b0, 4'h0});
    #1;
    chk("relaunch_pulse", {pc_valid, stall, busy}, 3'b110);
    step_drive();
    start = 1'b0;
    #1;
    chk("relaunch_rd_lo", {mem_rd, mem_addr}, {1'b1, 32'h401});
    repeat (3) step_drive();
    #1;
    chk("relaunch_done", {pc_valid, sp_we, flags_valid, stall}, 4'b1100);

    // Reset while in RD_HI of an RTI aborts it with no pulses.
    mem[32'h501] = 16'h0001; mem[32'h502] = 16'h0002; mem[32'h503] = 16'h000F;
    step_drive();
    start = 1'b1; restore_flags = 1'b1; sp_in = 32'h500;
    step_drive();
    start = 1'b0;
    step_drive();
    #1;
    chk("abort_in_rd_hi", {mem_rd, mem_addr}, {1'b1, 32'h502});
    rst = 1'b1;
    step_drive();
    rst = 1'b0;
    #1;
    chk("abort_reset_state",
        {busy, stall, mem_rd, mem_addr, pc_out, sp_out, flags_out, pc_valid, flags_valid, sp_we},
        '0);
    pulses = 0; rds = 0;
    for (int c = 0; c < 5; c++) begin
      step_drive();
      #1;
      if (pc_valid || sp_we || flags_valid) pulses++;
      if (mem_rd || busy) rds++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_idle", rds, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stack_unwind_unit.md
# stack_unwind_unit

Memory-stage sequencer that executes the pop side of the processor's multi-cycle stack protocol for RET and RTI. On a start pulse it reads the low PC word, the high PC word and, for RTI only, the saved flags word from consecutive stack addresses, one word per cycle. It then reassembles the 32-bit return PC and stalls the pipeline for the whole sequence. It delivers the PC redirect, the restored flags and the updated stack pointer as single-cycle pulses to fetch, the flag register and the SP register.

## Interface
- DATA_W, 16, memory word width
- ADDR_W, 32, stack pointer / address width
- FLAGS_W, 4, number of architectural flag bits restored from the flags word
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request from memory stage (RET/RTI present); sampled only in IDLE
- restore_flags  in  1  1 = RTI (also pop flags), 0 = RET; sampled with start
- sp_in  in  ADDR_W  current SP, sampled with start
- mem_rdata  in  DATA_W  data memory read data; synchronous memory, valid the cycle after mem_rd
- mem_rd  out  1  data memory read enable
- mem_addr  out  ADDR_W  data memory read address
- stall  out  1  freezes fetch/decode/execute while asserted
- busy  out  1  high in every non-IDLE state
- pc_out  out  2*DATA_W  reassembled return PC {hi, lo}
- pc_valid  out  1  one-cycle pulse: redirect fetch to pc_out
- flags_out  out  FLAGS_W  restored flags = flags word [FLAGS_W-1:0]
- flags_valid  out  1  one-cycle pulse, coincident with pc_valid, only for RTI
- sp_out  out  ADDR_W  new SP value
- sp_we  out  1  one-cycle pulse, coincident with pc_valid

## Operation
- Stack grows downward; SP points at the first free word. The popped layout is: PC low at SP+1, PC high at SP+2, flags at SP+3.
- States: IDLE, RD_LO, RD_HI, RD_FL, FIN.
- IDLE: when start=1, latch sp_base=sp_in and rti=restore_flags, then go to RD_LO. Otherwise stay in IDLE.
- RD_LO: mem_rd=1, mem_addr=sp_base+1. Next state RD_HI.
- RD_HI: lo_reg<=mem_rdata; mem_rd=1, mem_addr=sp_base+2. Next state RD_FL if rti, else FIN.
- RD_FL: hi_reg<=mem_rdata; mem_rd=1, mem_addr=sp_base+3. Next state FIN.
- FIN: mem_rd=0. The last read word is captured at the FIN edge:
  - RET: it is the high word.
  - RTI: it is the flags word.
  - At the same edge, register pc_out, sp_out and flags_out (RTI), and set pc_valid=1, sp_we=1 and flags_valid=rti. Next state IDLE.
- sp_out = sp_base+2 for RET, sp_base+3 for RTI.
- Address arithmetic is modulo 2^ADDR_W; SP=0xFFFFFFFF wraps so the low word is read at 0x00000000.
- Outside RD_* states, mem_addr = 0 and mem_rd = 0.
- stall = start (while IDLE) OR busy. This is combinational, so the start cycle is also stalled.
- start while busy is ignored. The upstream stall guarantees no new start arrives, but the unit must not corrupt an ongoing sequence if one does.
- pc_valid, flags_valid and sp_we are registered pulses lasting exactly one cycle: the first IDLE cycle after FIN.
- In that cycle a new start is accepted.
- pc_out, flags_out and sp_out hold their values until the next FIN.

## Timing
- Reset (rst=1 at a rising edge) forces:
  - state = IDLE;
  - stall, busy, mem_rd, pc_valid, flags_valid, sp_we = 0;
  - mem_addr, pc_out, sp_out, flags_out, lo_reg, hi_reg = 0.
- Reset mid-sequence aborts it: no pulses are produced and no SP write occurs.
- RET, with start accepted at edge 0:
  - cycles 1–3 are RD_LO, RD_HI, FIN;
  - pc_valid is high in cycle 4;
  - stall is high during cycles 0–3.
- RTI, with start accepted at edge 0:
  - cycles 1–4 are RD_LO, RD_HI, RD_FL, FIN;
  - pc_valid and flags_valid are high in cycle 5;
  - stall is high during cycles 0–4.
- mem_rd is high for exactly 2 cycles (RET) or 3 cycles (RTI) per sequence, with consecutive ascending addresses.

## Test plan
- RET, sp_in=0x0000_0100, mem[0x101]=0x5678, mem[0x102]=0x1234: pc_out=0x12345678, sp_out=0x102, pc_valid and sp_we one cycle at cycle 4, flags_valid=0, stall high cycles 0–3.
- RTI, sp_in=0x0000_0200, mem[0x201]=0xBEEF, mem[0x202]=0xDEAD, mem[0x203]=0x000A: pc_out=0xDEADBEEF, flags_out=4'hA, sp_out=0x203, all three pulses at cycle 5.
- SP wrap, RET with sp_in=0xFFFF_FFFF: mem_addr sequence is 0x00000000, then 0x00000001; sp_out=0x00000001.
- Reset asserted in RD_HI of an RTI: next cycle state is IDLE with all outputs 0, and no pulse in the following 5 cycles.
- start held high during an RET sequence: the second start is ignored while busy. A start present in the pulse cycle launches a new sequence, and its RD_LO follows immediately.
- Back-to-back RTI then RET: each produces exactly one set of pulses with correct values, and stall drops only in each pulse cycle.
